// File: rtl/pipe_pkg.sv
// Shared types and constants for the generic pipeline stage register.
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY,
    PS_ONE,
    PS_TWO
  } pipe_state_t;

  localparam logic [31:0] RV32I_NOP = 32'h00000013;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter; sticks at all-ones and is cleared only by reset.
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake, flush and stall counter.
// Define PIPE_REG_SKID_EN for a 2-entry skid buffer with a registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int          WIDTH     = 32,
  parameter logic [31:0] NOP_VALUE = RV32I_NOP,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [WIDTH-1:0] NOP_W = WIDTH'(NOP_VALUE);

  logic w_in_ready;
  logic w_out_valid;
  logic w_in_fire;
  logic w_out_fire;

  assign w_in_fire  = in_valid & w_in_ready;
  assign w_out_fire = w_out_valid & out_ready;

`ifdef PIPE_REG_SKID_EN

  pipe_state_t      r_state;
  pipe_state_t      w_state_next;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_skid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= PS_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = PS_EMPTY;
    end else begin
      case (r_state)
        PS_EMPTY: if (w_in_fire) w_state_next = PS_ONE;
        PS_ONE: begin
          if (w_in_fire && !w_out_fire)      w_state_next = PS_TWO;
          else if (w_out_fire && !w_in_fire) w_state_next = PS_EMPTY;
        end
        PS_TWO:   if (w_out_fire) w_state_next = PS_ONE;
        default:  w_state_next = PS_EMPTY;
      endcase
    end
  end

  always_comb begin
    w_in_ready  = !rst && !flush && (r_state != PS_TWO);
    w_out_valid = (r_state != PS_EMPTY);
  end

  // Head is always the oldest entry; skid only ever holds the second one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head <= NOP_W;
      r_skid <= NOP_W;
    end else if (flush) begin
      r_head <= NOP_W;
      r_skid <= NOP_W;
    end else begin
      case (r_state)
        PS_EMPTY: if (w_in_fire) r_head <= in_data;
        PS_ONE: begin
          if (w_in_fire && w_out_fire) r_head <= in_data;
          else if (w_in_fire)          r_skid <= in_data;
          else if (w_out_fire)         r_head <= NOP_W;
        end
        PS_TWO: begin
          if (w_out_fire) begin
            r_head <= r_skid;
            r_skid <= NOP_W;
          end
        end
        default: begin
          r_head <= NOP_W;
          r_skid <= NOP_W;
        end
      endcase
    end
  end

  assign out_data = r_head;

`else

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  assign w_in_ready  = !rst && !flush && (!r_valid || out_ready);
  assign w_out_valid = r_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= NOP_W;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_data  <= NOP_W;
    end else if (w_in_fire) begin
      r_valid <= 1'b1;
      r_data  <= in_data;
    end else if (w_out_fire) begin
      r_valid <= 1'b0;
      r_data  <= NOP_W;
    end
  end

  assign out_data = r_data;

`endif

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;

  pipe_sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (w_out_valid && !out_ready && !flush),
    .count(stall_cycles)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg; build with and without PIPE_REG_SKID_EN.
module tb_pipe_stage_reg;

`ifdef PIPE_REG_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [3:0]  stall_cycles;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] mq[$];
  int          stall_exp = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .WIDTH    (32),
    .NOP_VALUE(32'h00000013),
    .CNT_W    (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .stall_cycles(stall_cycles)
  );

  // Reference model: a FIFO of capacity CAP with the handshake rules applied directly.
  function automatic bit exp_ready();
    if (flush) return 1'b0;
    if (CAP == 2) return mq.size() < 2;
    return (mq.size() == 0) || out_ready;
  endfunction

  function automatic logic [31:0] exp_data();
    return (mq.size() > 0) ? mq[0] : 32'h13;
  endfunction

  task automatic cycle();
    bit infire, outfire, stl;
    infire  = in_valid && exp_ready();
    outfire = (mq.size() > 0) && out_ready;
    stl     = (mq.size() > 0) && !out_ready && !flush;
    @(posedge clk);
    if (flush) mq.delete();
    else begin
      if (outfire) void'(mq.pop_front());
      if (infire) mq.push_back(in_data);
    end
    if (stl && stall_exp < 15) stall_exp++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    mq.delete(); stall_exp = 0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(); #2;
    n_checks += 4;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    if (out_data !== 32'h13) begin n_fail++; $display("FAIL reset_data: got %h expected 00000013", out_data); end
    if (stall_cycles !== 4'h0) begin n_fail++; $display("FAIL reset_stall: got %h expected 0", stall_cycles); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
    in_valid = 1'b1; in_data = 32'h55; cycle();
    in_valid = 1'b0; cycle(); #2;
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL pre_rst_valid: got %b expected 1", out_valid); end
    rst = 1'b1; #1;
    n_checks += 4;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_valid: got %b expected 0", out_valid); end
    if (out_data !== 32'h13) begin n_fail++; $display("FAIL async_rst_data: got %h expected 00000013", out_data); end
    if (stall_cycles !== 4'h0) begin n_fail++; $display("FAIL async_rst_stall: got %h expected 0", stall_cycles); end
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL async_rst_ready: got %b expected 0", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0; mq.delete(); stall_exp = 0; #2;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %b expected 1", in_ready); end
    $display("test_reset done");
  endtask

  task automatic test_streaming();
    do_reset();
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1; in_data = k; #2;
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d]: got %b expected 1", k, in_ready); end
      cycle(); #2;
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 32'(k))
        begin n_fail++; $display("FAIL stream_out[%0d]: got v=%b d=%h expected v=1 d=%h", k, out_valid, out_data, k); end
      $display("stream in=%0d out=%h", k, out_data);
    end
    in_valid = 1'b0; cycle(); #2;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h13)
      begin n_fail++; $display("FAIL stream_drain: got v=%b d=%h expected v=0 d=00000013", out_valid, out_data); end
  endtask

  task automatic test_backpressure();
    logic [31:0] got[$];
    do_reset();
    in_valid = 1'b1; in_data = 32'hA; #2; cycle();
    in_data = 32'hB;
    for (int i = 0; i < 3; i++) begin
      bit f;
      #2;
      n_checks += 2;
      if (in_ready !== ((CAP == 2) && (i == 0)))
        begin n_fail++; $display("FAIL bp_ready[%0d]: got %b expected %b", i, in_ready, (CAP == 2) && (i == 0)); end
      if (out_data !== 32'hA) begin n_fail++; $display("FAIL bp_hold[%0d]: got %h expected 0000000a", i, out_data); end
      f = in_valid && in_ready;
      cycle();
      if (f) in_valid = 1'b0;
    end
    #2;
    n_checks++;
    if (stall_cycles !== 4'd3) begin n_fail++; $display("FAIL bp_stall: got %0d expected 3", stall_cycles); end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bit f;
      #2;
      if (out_valid) got.push_back(out_data);
      f = in_valid && in_ready;
      cycle();
      if (f) in_valid = 1'b0;
    end
    n_checks += 2;
    if (got.size() !== 2) begin n_fail++; $display("FAIL bp_count: got %0d expected 2", got.size()); end
    else if (got[0] !== 32'hA || got[1] !== 32'hB)
      begin n_fail++; $display("FAIL bp_order: got %h,%h expected a,b", got[0], got[1]); end
    if (stall_cycles !== 4'd3) begin n_fail++; $display("FAIL bp_stall_hold: got %0d expected 3", stall_cycles); end
    $display("backpressure delivered %0d entries", got.size());
  endtask

  task automatic test_flush();
    do_reset();
    in_valid = 1'b1; in_data = 32'hC; cycle();
`ifdef PIPE_REG_SKID_EN
    in_data = 32'hD; cycle();
`endif
    #2;
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_pre_valid: got %b expected 1", out_valid); end
    flush = 1'b1; in_data = 32'hE; #2;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b expected 0", in_ready); end
    cycle();
    flush = 1'b0; in_valid = 1'b0; #2;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h13)
      begin n_fail++; $display("FAIL flush_out: got v=%b d=%h expected v=0 d=00000013", out_valid, out_data); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(); #2;
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_ghost[%0d]: got v=%b d=%h expected v=0", i, out_valid, out_data); end
    end
    $display("flush done out_data=%h", out_data);
  endtask

  task automatic test_saturation();
    do_reset();
    in_valid = 1'b1; in_data = 32'h77; cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle(); #2;
      if (i == 9) begin
        n_checks++;
        if (stall_cycles !== 4'd10) begin n_fail++; $display("FAIL sat_mid: got %0d expected 10", stall_cycles); end
      end
    end
    n_checks++;
    if (stall_cycles !== 4'hF) begin n_fail++; $display("FAIL sat_final: got %h expected f", stall_cycles); end
    $display("saturation stall_cycles=%h", stall_cycles);
  endtask

  task automatic test_simultaneous();
    logic [31:0] nxt_in, nxt_out;
    do_reset();
    for (int k = 0; k < CAP; k++) begin
      in_valid = 1'b1; in_data = 32'(100 + k); cycle();
    end
    nxt_in = 32'(100 + CAP); nxt_out = 32'd100;
    out_ready = 1'b1; in_data = nxt_in;
    for (int i = 0; i < 10; i++) begin
      bit f;
      #2;
      n_checks += 2;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL simul_valid[%0d]: got %b expected 1", i, out_valid); end
      if (out_data !== nxt_out) begin n_fail++; $display("FAIL simul_order[%0d]: got %h expected %h", i, out_data, nxt_out); end
      nxt_out++;
      f = in_ready;
      cycle();
      if (f) begin nxt_in++; in_data = nxt_in; end
    end
    n_checks++;
    if (nxt_out !== 32'd110) begin n_fail++; $display("FAIL simul_count: got %0d expected 110", nxt_out); end
    in_valid = 1'b0;
    $display("simultaneous fire done next_out=%0d", nxt_out);
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bit f;
      if (!in_valid) begin
        in_valid = ($urandom_range(0, 2) != 0);
        if (in_valid) in_data = $urandom;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 19) == 0);
      #2;
      n_checks += 4;
      if (in_ready !== exp_ready())
        begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b expected %b", i, in_ready, exp_ready()); end
      if (out_valid !== (mq.size() > 0))
        begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b expected %b", i, out_valid, mq.size() > 0); end
      if (out_data !== exp_data())
        begin n_fail++; $display("FAIL rnd_data[%0d]: got %h expected %h", i, out_data, exp_data()); end
      if (stall_cycles !== 4'(stall_exp))
        begin n_fail++; $display("FAIL rnd_stall[%0d]: got %0d expected %0d", i, stall_cycles, stall_exp); end
      f = in_valid && exp_ready();
      cycle();
      if (f) in_valid = 1'b0;
    end
    flush = 1'b0;
    $display("random done occupancy=%0d stall=%0d", mq.size(), stall_exp);
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_saturation();
    test_simultaneous();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
